clk_div_mc: RTL

Multi-channel programmable clock divider, parametrised successor to the single-channel `clk_div`. It provides N independent divided-clock outputs, each with a W-bit divisor, per-channel enable, glitch-free divisor update at period boundaries, and a global phase-realignment strobe. It sits in the SoC clock/timing fabric and feeds peripheral baud/sample generators. `clk_o` is a registered logic-level signal, not routed as a real clock, and comes with a matching one-cycle `tick_o` strobe.

---
 rtl/clk_div_mc.sv | 99 +++++++++
 1 files changed

// File: rtl/clk_div_mc.sv
// clk_div_mc: N-channel programmable clock divider.
// Each channel owns an active divisor, a pending divisor with flag, and a
// phase counter. Handshake note: load_i/sync_i/en_i are plain level inputs
// sampled on every rising edge of clk_i; there is no valid/ready pairing,
// a load strobe is accepted unconditionally on the edge it is seen high.
// Outputs are registered; the phase register p_q holds the phase that the
// current clk_o/tick_o values describe.
module clk_div_mc #(
    parameter int W       = 8,
    parameter int N       = 4,
    parameter int DIV_RST = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N-1:0]     en_i,
    input  logic             sync_i,
    input  logic [N-1:0]     load_i,
    input  logic [N*W-1:0]   div_i,
    output logic [N-1:0]     clk_o,
    output logic [N-1:0]     tick_o,
    output logic [N-1:0]     pend_o
);

    localparam logic [W-1:0] ONE_W  = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W:0]   ONE_W1 = {{W{1'b0}}, 1'b1};
    localparam logic [W-1:0] D_RST  = W'(DIV_RST);

    for (genvar n = 0; n < N; n++) begin : g_ch
        logic [W-1:0] d_q;      // active divisor
        logic [W-1:0] pdiv_q;   // pending divisor
        logic         pend_q;   // pending divisor waiting to be applied
        logic [W-1:0] p_q;      // phase of the currently presented cycle
        logic         act_q;    // channel was counting on the previous edge
        logic         clk_q;
        logic         tick_q;

        logic         start;
        logic         phase0;
        logic         apply;
        logic [W-1:0] p_nxt;
        logic [W-1:0] d_eff;
        logic [W:0]   h_eff;

        // Next phase, divisor application decision and high time (W+1 bits).
        // A restart (sync, enable rising, or leaving D=0) is a phase-0 edge,
        // so a pending divisor is taken on it and used for that new period.
        always_comb begin
            start = sync_i | ~act_q | (d_q == '0);
            if (start || (p_q == d_q - ONE_W)) begin
                p_nxt = '0;
            end else begin
                p_nxt = p_q + ONE_W;
            end
            phase0 = (p_nxt == '0);
            apply  = pend_q & (~en_i[n] | phase0);
            d_eff  = apply ? pdiv_q : d_q;
            h_eff  = ({1'b0, d_eff} + ONE_W1) >> 1;
        end

        // Channel registers: divisor load/apply, then counting or idling.
        // A load on the same edge as an apply queues behind the applied value.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                d_q    <= D_RST;
                pdiv_q <= '0;
                pend_q <= 1'b0;
                p_q    <= '0;
                act_q  <= 1'b0;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
            end else begin
                if (apply) begin
                    d_q    <= pdiv_q;
                    pend_q <= 1'b0;
                end
                if (load_i[n]) begin
                    pdiv_q <= div_i[n*W +: W];
                    pend_q <= 1'b1;
                end
                if (!en_i[n] || (d_eff == '0)) begin
                    p_q    <= '0;
                    act_q  <= 1'b0;
                    clk_q  <= 1'b0;
                    tick_q <= 1'b0;
                end else begin
                    p_q    <= p_nxt;
                    act_q  <= 1'b1;
                    clk_q  <= ({1'b0, p_nxt} < h_eff);
                    tick_q <= phase0;
                end
            end
        end

        assign clk_o[n]  = clk_q;
        assign tick_o[n] = tick_q;
        assign pend_o[n] = pend_q;
    end

endmodule
